// File: rtl/xor_stream_decrypt.sv
// Receive-side framed stream decryptor. Each ciphertext byte is XORed with an 8-bit LFSR
// keystream that restarts from the loaded key at every start-of-frame. Plaintext leaves
// through a single registered valid/ready output stage.
module xor_stream_decrypt #(
    parameter logic [7:0]  LFSR_TAPS = 8'hB8,
    parameter int unsigned MAX_FRAME = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_key,
    input  logic [7:0]  key,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        err_nokey,
    output logic        err_frame,
    output logic [15:0] byte_cnt
);

    localparam logic [15:0] MaxCnt = 16'(MAX_FRAME);

    typedef enum logic [1:0] {StNoKey, StKeyed, StActive} state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_key, w_key;
    logic [7:0]  r_lfsr, w_lfsr;
    logic [15:0] r_byte_cnt, w_byte_cnt;
    logic        r_out_valid, w_out_valid;
    logic [7:0]  r_out_data, w_out_data;
    logic        r_out_sof, w_out_sof;
    logic        r_out_eof, w_out_eof;
    logic        r_err_nokey, w_err_nokey;
    logic        r_err_frame, w_err_frame;
    logic        w_acc;
    logic        w_last;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // A key load blocks the input for that cycle so the keystream change is unambiguous.
    assign in_ready = !load_key & (!r_out_valid | out_ready);
    assign w_acc    = in_valid & in_ready;
    // This byte would be the MAX_FRAME-th of the current frame.
    assign w_last   = (r_byte_cnt + 16'd1) == MaxCnt;

    // Next-state: key/keystream bookkeeping, framing FSM and output stage load.
    always_comb begin
        w_state     = r_state;
        w_key       = r_key;
        w_lfsr      = r_lfsr;
        w_byte_cnt  = r_byte_cnt;
        w_out_valid = r_out_valid & !out_ready;
        w_out_data  = r_out_data;
        w_out_sof   = r_out_sof;
        w_out_eof   = r_out_eof;
        w_err_nokey = 1'b0;
        w_err_frame = 1'b0;

        if (load_key) begin
            // A zero seed would lock the LFSR at zero.
            w_key      = (key == 8'h00) ? 8'h01 : key;
            w_lfsr     = (key == 8'h00) ? 8'h01 : key;
            w_byte_cnt = 16'd0;
            w_state    = StKeyed;
        end else if (w_acc) begin
            unique case (r_state)
                StNoKey: begin
                    w_err_nokey = 1'b1;
                end
                StKeyed, StActive: begin
                    if (in_sof) begin
                        // SOF while a frame is open means the previous EOF was lost.
                        w_err_frame = (r_state == StActive);
                        w_out_valid = 1'b1;
                        w_out_data  = in_data ^ r_key;
                        w_out_sof   = 1'b1;
                        w_out_eof   = in_eof;
                        w_lfsr      = lfsr_step(r_key);
                        w_byte_cnt  = 16'd1;
                        w_state     = in_eof ? StKeyed : StActive;
                    end else if (r_state == StKeyed) begin
                        w_err_frame = 1'b1;
                    end else begin
                        w_out_valid = 1'b1;
                        w_out_data  = in_data ^ r_lfsr;
                        w_out_sof   = 1'b0;
                        w_out_eof   = in_eof | w_last;
                        w_lfsr      = lfsr_step(r_lfsr);
                        if (in_eof || w_last) begin
                            w_err_frame = !in_eof;
                            w_byte_cnt  = 16'd0;
                            w_state     = StKeyed;
                        end else begin
                            w_byte_cnt = r_byte_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    w_state = StNoKey;
                end
            endcase
        end
    end

    // State and output registers; reset also forgets the key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StNoKey;
            r_key       <= 8'h00;
            r_lfsr      <= 8'h00;
            r_byte_cnt  <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_err_nokey <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_key       <= w_key;
            r_lfsr      <= w_lfsr;
            r_byte_cnt  <= w_byte_cnt;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_sof   <= w_out_sof;
            r_out_eof   <= w_out_eof;
            r_err_nokey <= w_err_nokey;
            r_err_frame <= w_err_frame;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign err_nokey = r_err_nokey;
    assign err_frame = r_err_frame;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_xor_stream_decrypt.sv
// Self-checking bench for xor_stream_decrypt: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level reference model.
module tb_xor_stream_decrypt;

    localparam int unsigned MaxFrame = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_key = 1'b0;
    logic [7:0]  key = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        err_nokey;
    logic        err_frame;
    logic [15:0] byte_cnt;

    xor_stream_decrypt #(
        .LFSR_TAPS(8'hB8),
        .MAX_FRAME(MaxFrame)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_key (load_key),
        .key      (key),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_eof   (in_eof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .err_nokey(err_nokey),
        .err_frame(err_frame),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: key presence, seed, frame position and the expected output register.
    bit         m_have_key;
    bit         m_in_frame;
    logic [7:0] m_seed;
    int         m_cnt;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_osof;
    bit         m_oeof;
    bit         m_enk;
    bit         m_efr;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keystream byte k of a frame is the seed advanced k times.
    function automatic logic [7:0] keystream(input logic [7:0] seed, input int k);
        logic [7:0] s;
        s = seed;
        for (int i = 0; i < k; i++) s = {s[6:0], ^(s & 8'hB8)};
        return s;
    endfunction

    task automatic model_reset();
        m_have_key = 0;
        m_in_frame = 0;
        m_seed     = 8'h00;
        m_cnt      = 0;
        m_ov       = 0;
        m_od       = 8'h00;
        m_osof     = 0;
        m_oeof     = 0;
        m_enk      = 0;
        m_efr      = 0;
    endtask

    // One clock cycle: drive, check in_ready, update model, check registered outputs.
    task automatic cyc(input bit lk, input logic [7:0] k, input bit v, input logic [7:0] d,
                       input bit s, input bit e, input bit ordy, output bit acc);
        bit exp_rdy;
        bit last;
        @(negedge clk);
        load_key  = lk;
        key       = k;
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        in_eof    = e;
        out_ready = ordy;
        #1;
        exp_rdy = !lk && (!m_ov || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && ordy) got.push_back(out_data);
        acc   = v && exp_rdy;
        m_enk = 0;
        m_efr = 0;
        if (m_ov && ordy) m_ov = 0;
        if (lk) begin
            m_seed     = (k == 8'h00) ? 8'h01 : k;
            m_have_key = 1;
            m_in_frame = 0;
            m_cnt      = 0;
        end else if (acc) begin
            if (!m_have_key) begin
                m_enk = 1;
            end else if (s) begin
                m_efr      = m_in_frame;
                m_ov       = 1;
                m_od       = d ^ m_seed;
                m_osof     = 1;
                m_oeof     = e;
                m_cnt      = 1;
                m_in_frame = !e;
            end else if (!m_in_frame) begin
                m_efr = 1;
            end else begin
                last       = e || (m_cnt + 1 == int'(MaxFrame));
                m_ov       = 1;
                m_od       = d ^ keystream(m_seed, m_cnt);
                m_osof     = 0;
                m_oeof     = last;
                m_efr      = last && !e;
                m_cnt      = last ? 0 : m_cnt + 1;
                m_in_frame = !last;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_sof", 32'(out_sof), 32'(m_osof));
            chk("out_eof", 32'(out_eof), 32'(m_oeof));
        end
        chk("err_nokey", 32'(err_nokey), 32'(m_enk));
        chk("err_frame", 32'(err_frame), 32'(m_efr));
        chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        load_key = 0;
        in_valid = 0;
        reset    = 0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        chk("rst_err", 32'({err_nokey, err_frame}), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1;
        got.delete();
    endtask

    task automatic chk_got(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
    endtask

    initial begin
        bit acc;
        bit tog;
        logic [7:0] f5[5];
        f5 = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        model_reset();
        #2;
        do_reset();

        // Bytes before any key are dropped with err_nokey; then key 00 acts as seed 01.
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 8'h40, i == 0, 0, 1, acc);
        chk("nokey_no_output", 32'(got.size()), 32'd0);
        cyc(1, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 8'h00, i == 0, i == 2, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        exp_q = '{8'h01, 8'h02, 8'h04};
        chk_got("zero_key_stream");

        // Key 01, 5-byte frame of 40s, then the same frame twice back to back.
        cyc(1, 8'h01, 0, 8'h00, 0, 0, 1, acc);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, f5[i], i == 0, i == 4, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        exp_q = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h51, 8'h41, 8'h42, 8'h44, 8'h48, 8'h51,
                  8'h41, 8'h42, 8'h44, 8'h48, 8'h51};
        chk_got("frame_repeat");

        // Same frame with out_ready toggling; each byte held until accepted.
        tog = 0;
        for (int i = 0; i < 5; i++) begin
            acc = 0;
            for (int t = 0; t < 10 && !acc; t++) begin
                tog = !tog;
                cyc(0, 8'h00, 1, 8'h40, i == 0, i == 4, tog, acc);
            end
            chk("stall_accept", 32'(acc), 32'd1);
        end
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        exp_q = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h51};
        chk_got("stalled_frame");

        // Missing EOF: new SOF restarts keystream; then a non-SOF byte while waiting for SOF.
        cyc(0, 8'h00, 1, 8'h40, 1, 0, 1, acc);
        cyc(0, 8'h00, 1, 8'h40, 0, 0, 1, acc);
        cyc(0, 8'h00, 1, 8'h40, 1, 0, 1, acc);
        cyc(0, 8'h00, 1, 8'h40, 0, 1, 1, acc);
        cyc(0, 8'h00, 1, 8'h40, 0, 0, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        exp_q = '{8'h41, 8'h42, 8'h41, 8'h42};
        chk_got("missing_eof");

        // Oversize frame: byte MaxFrame gets forced EOF; the rest are dropped.
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 8'h40, i == 0, i == 7, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        exp_q = '{8'h41, 8'h42, 8'h44, 8'h48, 8'h51, 8'h63};
        chk_got("oversize");

        // Asynchronous reset in the middle of a frame discards frame and key.
        cyc(0, 8'h00, 1, 8'h40, 1, 0, 1, acc);
        cyc(0, 8'h00, 1, 8'h40, 0, 0, 0, acc);
        #2;
        do_reset();
        cyc(0, 8'h00, 1, 8'h40, 1, 0, 1, acc);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1, acc);
        chk("post_reset_no_output", 32'(got.size()), 32'd0);

        // Randomized traffic against the model.
        cyc(1, 8'($urandom), 0, 8'h00, 0, 0, 1, acc);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 60) == 0, 8'($urandom), ($urandom % 4) != 0, 8'($urandom),
                ($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 3) != 0, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
